// File: rtl/gpr_writeback_pkg.sv
// -----------------------------------------------------------------------------
// gpr_wb_pkg
// Shared types and constants for the GPR write-back slice.
//   XLEN        : register width
//   F3_*        : load funct3 encodings understood by the aligner
//   wb_entry_t  : one pending register write {rd, data}
//   reg_hit()   : a nonzero source register matching a destination register
// -----------------------------------------------------------------------------
package gpr_wb_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // x0 is hardwired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] qs, input logic [4:0] rd);
    return (qs != 5'd0) && (qs == rd);
  endfunction

endpackage

// File: rtl/gpr_writeback_if.sv
// -----------------------------------------------------------------------------
// gpr_writeback_if
// Bundles the ALU and LSU result handshakes, the decode-stage hazard query and
// the GPR file write port.
//   master : the pipeline side (offers results, asks about hazards, consumes
//            the write port)
//   slave  : gpr_writeback itself
// -----------------------------------------------------------------------------
interface gpr_writeback_if;
  import gpr_wb_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [2:0]      lsu_funct3;
  logic [1:0]      lsu_offset;
  logic [XLEN-1:0] lsu_rdata;

  logic [4:0]      query_rs1;
  logic [4:0]      query_rs2;
  logic            hazard;

  logic            RegWEn;
  logic [4:0]      addr_towrite;
  logic [XLEN-1:0] data_towrite;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_funct3, lsu_offset, lsu_rdata,
    output query_rs1, query_rs2,
    input  alu_ready, lsu_ready, hazard,
    input  RegWEn, addr_towrite, data_towrite
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_funct3, lsu_offset, lsu_rdata,
    input  query_rs1, query_rs2,
    output alu_ready, lsu_ready, hazard,
    output RegWEn, addr_towrite, data_towrite
  );

endinterface

// File: rtl/gpr_writeback_load_align.sv
// -----------------------------------------------------------------------------
// wb_load_align
// Combinational load formatter: picks the byte/half addressed by offset out of
// the raw memory word and sign- or zero-extends it.
//   funct3 : load type (LB/LH/LW/LBU/LHU), anything else yields 0
//   offset : byte address [1:0]
//   rdata  : raw aligned memory word
//   result : formatted register value
// Misaligned halves/words are not trapped: the half is chosen by offset[1]
// only and LW ignores offset entirely.
// -----------------------------------------------------------------------------
module wb_load_align
  import gpr_wb_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   result = rdata;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/gpr_writeback.sv
// -----------------------------------------------------------------------------
// gpr_writeback
// Write-side master of the GPR file. Merges 1-cycle ALU results with formatted
// LSU load responses (queued in a DEPTH-entry FIFO) into a single registered
// write port, and flags decode-stage hazards against writes still in flight.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : gpr_writeback_if.slave (ALU/LSU handshakes, hazard query,
//              RegWEn/addr_towrite/data_towrite)
//   pending  : FIFO occupancy, 0..DEPTH
// Arbitration: ALU wins over the FIFO head unless the FIFO is full; while full
// both inputs are back-pressured and the head drains.
// Optional build macro GPR_WB_BYPASS_EN: with the FIFO empty and no ALU offer,
// a load skips the FIFO and is written one cycle after acceptance.
// -----------------------------------------------------------------------------
module gpr_writeback
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  gpr_writeback_if.slave         bus,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic            fifo_full;
  logic            fifo_empty;
  logic            alu_take;
  logic            lsu_take;
  logic            push;
  logic            pop;
  logic            bypass;
  logic            sel_valid;
  wb_entry_t       sel_entry;
  logic [XLEN-1:0] load_fmt;
  wb_entry_t       lsu_entry;
  logic            hazard;

  wb_load_align u_align (
    .funct3 (bus.lsu_funct3),
    .offset (bus.lsu_offset),
    .rdata  (bus.lsu_rdata),
    .result (load_fmt)
  );

  assign lsu_entry  = '{rd: bus.lsu_rd, data: load_fmt};
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);

  assign bus.alu_ready = !fifo_full;
  assign bus.lsu_ready = !fifo_full;
  assign alu_take      = bus.alu_valid && !fifo_full;
  assign lsu_take      = bus.lsu_valid && !fifo_full;
  assign pending       = count;

  // Write-slot arbiter: ALU, then FIFO head, then (optionally) a bypassed load.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (alu_take) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: bus.alu_rd, data: bus.alu_data};
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_entry = mem[rd_ptr];
      pop       = 1'b1;
`ifdef GPR_WB_BYPASS_EN
    end else if (lsu_take) begin
      // Empty FIFO and no ALU offer (alu_take is only low here if alu_valid
      // is low), so the load can take the slot directly.
      sel_valid = 1'b1;
      sel_entry = lsu_entry;
      bypass    = 1'b1;
`endif
    end
  end

  // lsu_take already excludes the full case, so a push never overflows.
  assign push = lsu_take && !bypass;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      // Push and pop never address the same slot: pop needs a non-empty FIFO
      // and push a non-full one, and both at once leaves distinct pointers.
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the valid bits and pointers decide
  // what is live, so stale payload is never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lsu_entry;
  end

  // Output stage. A slot aimed at x0 still consumes the cycle but never
  // raises RegWEn; address/data only move on a real write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.RegWEn       <= 1'b0;
      bus.addr_towrite <= '0;
      bus.data_towrite <= '0;
    end else begin
      bus.RegWEn <= sel_valid && (sel_entry.rd != 5'd0);
      if (sel_valid && (sel_entry.rd != 5'd0)) begin
        bus.addr_towrite <= sel_entry.rd;
        bus.data_towrite <= sel_entry.data;
      end
    end
  end

  // Hazard looks only at registered state: queued loads and the write being
  // presented to the register file this cycle.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (reg_hit(bus.query_rs1, mem[i].rd) ||
                       reg_hit(bus.query_rs2, mem[i].rd)))
        hazard = 1'b1;
    end
    if (bus.RegWEn && (reg_hit(bus.query_rs1, bus.addr_towrite) ||
                       reg_hit(bus.query_rs2, bus.addr_towrite)))
      hazard = 1'b1;
  end

  assign bus.hazard = hazard;

endmodule

// File: tb/tb_gpr_writeback.sv
// -----------------------------------------------------------------------------
// tb_gpr_writeback
// Self-checking bench for gpr_writeback. A transaction-level model (a queue of
// pending loads plus the last write) predicts ready, pending, hazard and the
// write port every cycle. A table of load-format vectors, hand sequences for
// the arbitration/full/x0/reset corners and a randomized phase drive it.
// Honors GPR_WB_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_gpr_writeback;

  localparam int DEPTH = 4;
`ifdef GPR_WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] pending;

  gpr_writeback_if bus ();

  gpr_writeback #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      3'd2:    return w;
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_hazard(input logic [4:0] qs);
    logic hit;
    hit = 1'b0;
    if (qs == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == qs) hit = 1'b1;
    if (m_we && m_addr == qs) hit = 1'b1;
    return hit;
  endfunction

  // One clock cycle: drive, check the combinational view, predict, clock,
  // check the write port. Starts and ends 1 ns after a rising edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                      input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                      input logic [1:0] off, input logic [31:0] rdata,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    ent_t w;
    logic wv, full, byp;
    bus.alu_valid  = av;
    bus.alu_rd     = ard;
    bus.alu_data   = adata;
    bus.lsu_valid  = lv;
    bus.lsu_rd     = lrd;
    bus.lsu_funct3 = f3;
    bus.lsu_offset = off;
    bus.lsu_rdata  = rdata;
    bus.query_rs1  = rs1;
    bus.query_rs2  = rs2;
    #1;
    full = (q.size() == DEPTH);
    check("alu_ready", 32'(bus.alu_ready), 32'(!full));
    check("lsu_ready", 32'(bus.lsu_ready), 32'(!full));
    check("pending", 32'(pending), 32'(q.size()));
    check("hazard", 32'(bus.hazard), 32'(model_hazard(rs1) || model_hazard(rs2)));
    wv  = 1'b0;
    byp = 1'b0;
    w   = '0;
    if (av && !full) begin
      w  = '{ard, adata};
      wv = 1'b1;
    end else if (q.size() > 0) begin
      w  = q.pop_front();
      wv = 1'b1;
`ifdef GPR_WB_BYPASS_EN
    end else if (lv) begin
      w   = '{lrd, ref_load(f3, off, rdata)};
      wv  = 1'b1;
      byp = 1'b1;
`endif
    end
    if (lv && !full && !byp) q.push_back('{lrd, ref_load(f3, off, rdata)});
    m_we = wv && (w.rd != 5'd0);
    if (m_we) begin
      m_addr = w.rd;
      m_data = w.data;
    end
    @(posedge clk);
    #1;
    check("RegWEn", 32'(bus.RegWEn), 32'(m_we));
    if (m_we) begin
      check("addr_towrite", 32'(bus.addr_towrite), 32'(m_addr));
      check("data_towrite", bus.data_towrite, m_data);
    end
  endtask

  task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0, rs1, rs2);
  endtask

  // ---------------- load-format table ----------------
  typedef struct packed {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } align_vec_t;

  align_vec_t vecs [12];

  initial begin
    vecs[0]  = '{3'b000, 2'd3, 32'h8012_3456, 32'hFFFF_FF80};  // LB sign
    vecs[1]  = '{3'b100, 2'd3, 32'h8012_3456, 32'h0000_0080};  // LBU
    vecs[2]  = '{3'b000, 2'd0, 32'h8012_3456, 32'h0000_0056};  // LB positive
    vecs[3]  = '{3'b000, 2'd1, 32'h0000_F100, 32'hFFFF_FFF1};
    vecs[4]  = '{3'b001, 2'd2, 32'h8012_3456, 32'hFFFF_8012};  // LH sign
    vecs[5]  = '{3'b101, 2'd2, 32'h8012_3456, 32'h0000_8012};  // LHU
    vecs[6]  = '{3'b001, 2'd1, 32'h8012_3456, 32'h0000_3456};  // misaligned LH
    vecs[7]  = '{3'b101, 2'd3, 32'hABCD_0000, 32'h0000_ABCD};  // misaligned LHU
    vecs[8]  = '{3'b010, 2'd0, 32'h8012_3456, 32'h8012_3456};  // LW
    vecs[9]  = '{3'b010, 2'd3, 32'hCAFE_F00D, 32'hCAFE_F00D};  // misaligned LW
    vecs[10] = '{3'b011, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000};  // illegal funct3
    vecs[11] = '{3'b110, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000};

    q.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    rst    = 1'b1;
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_data   = '0;
    bus.lsu_valid  = 1'b0;
    bus.lsu_rd     = '0;
    bus.lsu_funct3 = '0;
    bus.lsu_offset = '0;
    bus.lsu_rdata  = '0;
    bus.query_rs1  = '0;
    bus.query_rs2  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_RegWEn", 32'(bus.RegWEn), 32'd0);
    check("rst_addr", 32'(bus.addr_towrite), 32'd0);
    check("rst_data", bus.data_towrite, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    rst = 1'b0;

    // ALU only: 1-cycle latency
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    check("alu_only_we", 32'(bus.RegWEn), 32'd1);
    check("alu_only_addr", 32'(bus.addr_towrite), 32'd5);
    check("alu_only_data", bus.data_towrite, 32'hDEAD_BEEF);
    idle(5'd0, 5'd0);

    // Load format table, each load isolated so its latency is observable
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), vecs[i].f3, vecs[i].off, vecs[i].rdata,
           5'd0, 5'd0);
      repeat (LAT - 1) idle(5'd0, 5'd0);
      check("align_we", 32'(bus.RegWEn), 32'd1);
      check("align_addr", 32'(bus.addr_towrite), 32'(i + 1));
      check("align_data", bus.data_towrite, vecs[i].exp);
      idle(5'd0, 5'd0);
    end

    // ALU and LSU in the same cycle: ALU first, load next, hazard on rd=2
    step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 3'b010, 2'd0, 32'h2222_2222, 5'd2, 5'd0);
    check("both_first_addr", 32'(bus.addr_towrite), 32'd1);
    check("both_hz_queued", 32'(bus.hazard), 32'd1);
    idle(5'd2, 5'd0);
    check("both_second_addr", 32'(bus.addr_towrite), 32'd2);
    check("both_second_data", bus.data_towrite, 32'h2222_2222);
    check("both_hz_writing", 32'(bus.hazard), 32'd1);
    idle(5'd2, 5'd0);
    check("both_hz_clear", 32'(bus.hazard), 32'd0);

    // Fill the FIFO while the ALU streams
    for (int k = 0; k < 4; k++)
      step(1'b1, 5'(10 + k), 32'(k), 1'b1, 5'(20 + k), 3'b010, 2'd0, 32'(100 + k),
           5'd0, 5'd0);
    check("full_pending", 32'(pending), 32'd4);
    check("full_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("full_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    step(1'b1, 5'd14, 32'd4, 1'b1, 5'd24, 3'b010, 2'd0, 32'd104, 5'd0, 5'd0);
    check("drain_pending", 32'(pending), 32'd3);
    check("drain_addr", 32'(bus.addr_towrite), 32'd20);
    check("drain_alu_ready", 32'(bus.alu_ready), 32'd1);
    step(1'b1, 5'd14, 32'd4, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    check("resume_addr", 32'(bus.addr_towrite), 32'd14);
    repeat (4) idle(5'd0, 5'd0);
    check("drained_pending", 32'(pending), 32'd0);

    // rd = 0 on both sides: handshakes complete, nothing is written
    step(1'b1, 5'd0, 32'hAAAA_AAAA, 1'b1, 5'd0, 3'b010, 2'd0, 32'hBBBB_BBBB, 5'd0, 5'd0);
    check("x0_alu_we", 32'(bus.RegWEn), 32'd0);
    check("x0_pending", 32'(pending), 32'd1);
    check("x0_hazard", 32'(bus.hazard), 32'd0);
    idle(5'd0, 5'd0);
    check("x0_load_we", 32'(bus.RegWEn), 32'd0);
    check("x0_empty", 32'(pending), 32'd0);

    // Reset with three queued loads
    for (int k = 0; k < 3; k++)
      step(1'b1, 5'(3 + k), 32'(k), 1'b1, 5'(6 + k), 3'b010, 2'd0, 32'(k), 5'd0, 5'd0);
    check("pre_rst_pending", 32'(pending), 32'd3);
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_we", 32'(bus.RegWEn), 32'd0);
    q.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) idle(5'd6, 5'd7);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    repeat (6) idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
